spram_arbiter: RTL
==================

// Module: spram_arbiter
// PURPOSE
//  Shares one spram instance (single port, 1-cycle sync read) between NREQ requesters,
//  e.g. host load DMA, systolic-array operand fetch and result writeback.
//  Round-robin grant, one access per cycle; read data is routed back to the
//  issuing requester with fixed latency. Sits between the array controller and its buffer RAM.
// PARAMETERS
//  NREQ  3   number of requesters (2..8)
//  AW    12  RAM address width
//  DW    16  RAM data width
// PORTS
//  clk        in   1         single clock, all logic posedge
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   NREQ      requester i has an access pending
//  req_we     in   NREQ      1=write, 0=read (per requester)
//  req_addr   in   NREQ*AW   slice i = [i*AW +: AW]
//  req_wdata  in   NREQ*DW   slice i = [i*DW +: DW]
//  req_ready  out  NREQ      one-hot (or 0): requester i accepted this cycle
//  rsp_valid  out  NREQ      one-hot (or 0): read data for requester i on rsp_rdata
//  rsp_rdata  out  DW        read data, shared by all requesters
//  grant_id   out  $clog2(NREQ) index of last granted requester (debug/perf)
// BEHAVIOUR
//  - Handshake: access i transfers in a cycle where req_valid[i] && req_ready[i].
//    Requester holds we/addr/wdata stable while valid && !ready. req_ready is combinational
//    from req_valid and the rr pointer; no dependence of ready on ready.
//  - Arbitration: rr pointer ptr (reset 0). Search order ptr, ptr+1, ... mod NREQ; first
//    valid wins. After a grant to k, ptr <= (k+1) mod NREQ. No grant -> ptr unchanged.
//    Guarantees each valid requester is served within NREQ cycles.
//  - Issue: granted request drives spram addr/we/din same cycle (combinational mux).
//    No grant -> spram we=0, addr held at last value (no spurious write).
//  - Read latency 1: read accepted in cycle t -> rsp_valid[k]=1 and rsp_rdata valid in t+1.
//    Back-to-back reads from any mix of requesters sustain 1 read/cycle.
//  - Writes produce no response; rsp_valid stays 0 in the cycle after a write (spram dout
//    returns old data then and is ignored).
//  - Read-after-write, same address, consecutive cycles: read returns new data.
//    Same-cycle conflicts impossible (one grant per cycle).
//  - Responses cannot be back-pressured; requester must accept rsp in the valid cycle.
//  - rsp_rdata when rsp_valid==0: don't-care, not X-checked beyond no-hang.
//  - Reset: req_ready=0 during rst; after reset rsp_valid=0, grant_id=0, ptr=0.
//    Reset mid-operation: a read accepted in the cycle before rst asserts gets no rsp
//    (rsp_valid forced 0 while rst high); RAM contents not cleared.
//  - State: ptr, rd_pend (1b), rd_id; all other outputs derived.
// STRUCTURE
//  - Package sa_mem_pkg: localparam REQ_IDW = $clog2(NREQ) helper, typedef mem_req_t
//    {we, addr, wdata} shared with DMA/fetch blocks.
//  - Sub-module: rr_arbiter #(N) (req, ptr -> one-hot gnt, gnt_idx, any);
//    spram instantiated directly inside spram_arbiter.
// TESTING
//  1. Single requester: r1 writes 0xBEEF @0x010, then reads 0x010 -> ready same cycle,
//     rsp_valid=3'b010 and rsp_rdata=0xBEEF one cycle after the read.
//  2. All three valid continuously with reads -> grant order 0,1,2,0,1,2; one rsp/cycle,
//     each tagged to correct requester, no gaps.
//  3. r0 writes 0x1234 @0x020 cycle t, r2 reads 0x020 cycle t+1 -> r2 gets 0x1234 at t+2;
//     no rsp_valid at t+1.
//  4. r1 valid with ptr=2 and r2 idle -> r1 served immediately (skip idle), ptr becomes 2.
//  5. Read accepted, rst asserted next cycle -> rsp_valid=0, req_ready=0 throughout reset;
//     after release ptr=0 and previously written data still readable.
//  6. Random traffic vs. reference memory model: every read matches model, every valid
//     requester granted within NREQ cycles.

Source files
------------

// File: rtl/sa_mem_pkg.sv
// Shared types and helpers for blocks that talk to the systolic-array buffer RAM.
package sa_mem_pkg;

    localparam int MEM_AW = 12;
    localparam int MEM_DW = 16;

    // One RAM access as issued by a DMA / fetch / writeback client
    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;

    // Width of a requester index; never narrower than one bit
    function automatic int req_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and the first
// asserted request wins. The caller owns and advances the pointer.
module rr_arbiter
    import sa_mem_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = req_idw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0]  gnt_s;
    logic [IW-1:0] idx_s;
    logic          any_s;

    // Rotating-priority search: ptr, ptr+1, ... wrapping at N
    always_comb begin
        int cand;
        gnt_s = '0;
        idx_s = '0;
        any_s = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!any_s && req[cand]) begin
                gnt_s[cand] = 1'b1;
                idx_s       = IW'(cand);
                any_s       = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
    end

    assign gnt     = gnt_s;
    assign gnt_idx = idx_s;
    assign any     = any_s;

endmodule

// File: rtl/spram_arbiter.sv
// Shares a single-port, 1-cycle-read RAM among NREQ requesters with
// round-robin arbitration. Read data returns one cycle after acceptance,
// tagged with the issuing requester.
module spram_arbiter
    import sa_mem_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = 12,
    parameter int DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_wdata,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [DW-1:0]           rsp_rdata,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int IW = req_idw(NREQ);

    // Arbitration
    logic [NREQ-1:0] arb_req_s;
    logic [NREQ-1:0] gnt_s;
    logic [IW-1:0]   gnt_idx_s;
    logic            any_s;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   ptr_nxt_s;

    // Read tracking and debug
    logic            rd_pend_r;
    logic [IW-1:0]   rd_id_r;
    logic [IW-1:0]   grant_id_r;
    logic [NREQ-1:0] rsp_valid_s;

    // RAM port
    logic [AW-1:0]   last_addr_r;
    logic [AW-1:0]   mem_addr_s;
    logic            mem_we_s;
    logic [DW-1:0]   mem_din_s;
    logic [DW-1:0]   mem_dout_r;
    logic [DW-1:0]   mem_r [0:(1<<AW)-1];

    // Nobody is granted while reset is held
    assign arb_req_s = req_valid & ~{NREQ{rst}};

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req     (arb_req_s),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    assign req_ready = gnt_s;

    // Route the granted requester onto the RAM port; idle cycles hold the address and never write
    always_comb begin
        mem_addr_s = last_addr_r;
        mem_we_s   = 1'b0;
        mem_din_s  = '0;
        if (any_s) begin
            mem_addr_s = req_addr[gnt_idx_s*AW +: AW];
            mem_we_s   = req_we[gnt_idx_s];
            mem_din_s  = req_wdata[gnt_idx_s*DW +: DW];
        end else begin
            mem_addr_s = last_addr_r;
        end
    end

    // Pointer moves to the requester after the winner; unchanged when nobody is granted
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (any_s) begin
            if (gnt_idx_s == IW'(NREQ - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = gnt_idx_s + IW'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Arbiter pointer, pending-read tag, debug grant index and held RAM address
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= '0;
            rd_pend_r   <= 1'b0;
            rd_id_r     <= '0;
            grant_id_r  <= '0;
            last_addr_r <= '0;
        end else begin
            ptr_r     <= ptr_nxt_s;
            rd_pend_r <= any_s && !mem_we_s;
            if (any_s) begin
                rd_id_r     <= gnt_idx_s;
                grant_id_r  <= gnt_idx_s;
                last_addr_r <= mem_addr_s;
            end
        end
    end

    // Single-port RAM, read-first with a registered output; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_din_s;
        end
        mem_dout_r <= mem_r[mem_addr_s];
    end

    // Response strobe for the requester whose read is in flight; a read caught by reset is dropped
    always_comb begin
        rsp_valid_s = '0;
        if (rd_pend_r && !rst) begin
            rsp_valid_s[rd_id_r] = 1'b1;
        end else begin
            rsp_valid_s = '0;
        end
    end

    assign rsp_valid = rsp_valid_s;
    assign rsp_rdata = mem_dout_r;
    assign grant_id  = grant_id_r;

endmodule
